// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg
//   Shared types for the sequential radix-4 Booth multiply-accumulate stage.
//   - state_t       : FSM state encoding (IDLE, RUN, DONE)
//   - booth_digit_t : Booth digit encoding (ZERO, P1, P2, M1, M2)
//   - booth_decode  : maps a multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//                     to its Booth digit
package booth_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_t;

  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    booth_digit_t d;
    case (triplet)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO; // 000 and 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel
//   Combinational Booth partial-product selector.
//   Ports:
//     triplet [2:0]         multiplier bit triplet for the current digit
//     mcand   [2*WIDTH-1:0] sign-extended multiplicand A
//     pp      [2*WIDTH-1:0] selected partial product: 0, +A, +2A, -A or -2A
//   All values are two's complement modulo 2^(2*WIDTH); 2A always fits
//   because mcand carries WIDTH bits of sign extension.
module booth_pp_sel
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]         triplet,
  input  logic [2*WIDTH-1:0] mcand,
  output logic [2*WIDTH-1:0] pp
);

  booth_digit_t digit;

  always_comb begin
    digit = booth_decode(triplet);
    pp    = '0;
    case (digit)
      P1:      pp = mcand;
      P2:      pp = mcand << 1;
      M1:      pp = -mcand;
      M2:      pp = -(mcand << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_accumulator.sv
// booth_seq_accumulator
//   Sequential radix-4 Booth multiplier: one Booth partial product is added
//   per clock into a 2*WIDTH-bit accumulator. One operation in flight.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid / in_ready   operand handshake (a, b two's complement)
//     a, b [WIDTH-1:0]      multiplicand, multiplier
//     out_valid / out_ready product handshake
//     product [2*WIDTH-1:0] signed product a*b
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   in_ready is high only in IDLE (and never while rst_n is low);
//   out_valid is high only in DONE, with product held stable until the
//   transfer edge.
//   Optional feature: define BOOTH_SEQ_ACCUMULATOR_EARLY_EXIT_EN to leave
//   RUN as soon as the remaining multiplier bits are all zeros or all ones.
//   The FSM state is the internal signal `state` (type state_t).
module booth_seq_accumulator
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] LAST_K = KW'(WIDTH / 2 - 1);

  state_t          state, state_next;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH:0]  mplr;
  logic [KW-1:0]   k;
  logic [PW-1:0]   pp;
  logic            exit_now;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .triplet (mplr[2:0]),
    .mcand   (mcand),
    .pp      (pp)
  );

`ifdef BOOTH_SEQ_ACCUMULATOR_EARLY_EXIT_EN
  // Remaining triplets all decode to 0 once the shifted multiplier is a
  // pure sign run, so nothing further can change acc.
  assign exit_now = (mplr == '0) || (&mplr);
`else
  assign exit_now = 1'b0;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (exit_now || (k == LAST_K)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= {{WIDTH{a[WIDTH-1]}}, a};
            mplr  <= {b, 1'b0};
            acc   <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          if (!exit_now) begin
            // Digit k has weight 4^k, i.e. a left shift of 2k.
            acc  <= acc + (pp << {k, 1'b0});
            mplr <= {{2{mplr[WIDTH]}}, mplr[WIDTH:2]};
            k    <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
